// File: rtl/apb_master_ctrl.sv
// APB4 master stage of the AXI-APB bridge.
// Takes one decoded single-beat request at a time, selects the target slave
// by address range, runs SETUP/ACCESS with wait states and a timeout, and
// returns read data and status over a valid/ready response channel.
//
// state  | meaning
// IDLE   | ready for a request (cmd_ready=1)
// SETUP  | psel driven, penable low, one cycle
// ACCESS | penable high, waiting on pready or timeout
// RESP   | rsp_valid high, waiting on rsp_ready
`timescale 1ns/1ps
module apb_master_ctrl #(
    parameter int          SLAVE_NUM      = 4,
    parameter logic [31:0] A_START_SLAVE0 = 32'h0000_0000,
    parameter logic [31:0] A_END_SLAVE0   = 32'h0000_0FFF,
    parameter logic [31:0] A_START_SLAVE1 = 32'h0000_1000,
    parameter logic [31:0] A_END_SLAVE1   = 32'h0000_1FFF,
    parameter logic [31:0] A_START_SLAVE2 = 32'h0000_2000,
    parameter logic [31:0] A_END_SLAVE2   = 32'h0000_2FFF,
    parameter logic [31:0] A_START_SLAVE3 = 32'h0000_3000,
    parameter logic [31:0] A_END_SLAVE3   = 32'h0000_3FFF,
    parameter int          TIMEOUT        = 16
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [31:0]               cmd_addr,
    input  logic                      cmd_write,
    input  logic [31:0]               cmd_wdata,
    input  logic [3:0]                cmd_strb,
    input  logic [2:0]                cmd_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic [1:0]                rsp_err,
    output logic [SLAVE_NUM-1:0]      psel,
    output logic                      penable,
    output logic [31:0]               paddr,
    output logic                      pwrite,
    output logic [31:0]               pwdata,
    output logic [3:0]                pstrb,
    output logic [2:0]                pprot,
    input  logic [SLAVE_NUM-1:0]      pready,
    input  logic [32*SLAVE_NUM-1:0]   prdata,
    input  logic [SLAVE_NUM-1:0]      pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] RANGE_LO [4] = '{A_START_SLAVE0, A_START_SLAVE1,
                                              A_START_SLAVE2, A_START_SLAVE3};
    localparam logic [31:0] RANGE_HI [4] = '{A_END_SLAVE0, A_END_SLAVE1,
                                              A_END_SLAVE2, A_END_SLAVE3};

    state_t             state, state_nxt;
    logic               dec_hit;
    logic [3:0]         dec_onehot;
    logic               pready_sel, pslverr_sel;
    logic [31:0]        prdata_sel;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               tmo_hit;

    assign cmd_ready   = (state == IDLE);
    assign pready_sel  = |(pready & psel);
    assign pslverr_sel = |(pslverr & psel);
    assign tmo_hit     = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // Address decode; the range check is done as an unsigned offset compare, lowest index wins
    always_comb begin
        dec_hit    = 1'b0;
        dec_onehot = '0;
        for (int i = 3; i >= 0; i--) begin
            if (i < SLAVE_NUM &&
                (cmd_addr - RANGE_LO[i]) <= (RANGE_HI[i] - RANGE_LO[i])) begin
                dec_hit    = 1'b1;
                dec_onehot = '0;
                dec_onehot[i] = 1'b1;
            end
        end
    end

    // Read data of the slave currently selected (psel is one-hot while busy)
    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (psel[i]) prdata_sel = prdata_sel | prdata[32*i +: 32];
        end
    end

    // State register
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = dec_hit ? SETUP : RESP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready_sel || tmo_hit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered APB bus, response and timeout counter
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            psel      <= '0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            pprot     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 2'b00;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (dec_hit) begin
                            psel    <= dec_onehot[SLAVE_NUM-1:0];
                            paddr   <= cmd_addr;
                            pwrite  <= cmd_write;
                            pprot   <= cmd_prot;
                            pwdata  <= cmd_write ? cmd_wdata : 32'h0;
                            pstrb   <= cmd_write ? cmd_strb : 4'h0;
                            tmo_cnt <= '0;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_err   <= 2'b11;
                        end
                    end
                end
                SETUP: penable <= 1'b1;
                ACCESS: begin
                    if (pready_sel) begin
                        psel      <= '0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pwrite ? 32'h0 : prdata_sel;
                        rsp_err   <= pslverr_sel ? 2'b10 : 2'b00;
                    end else if (tmo_hit) begin
                        psel      <= '0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 2'b10;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Testbench for apb_master_ctrl: directed scenarios plus randomized
// transactions compared against an address-map / wait-count reference model.
`timescale 1ns/1ps
module tb_apb_master_ctrl;
    localparam int SN  = 4;
    localparam int TMO = 16;

    logic pclk = 1'b0;
    logic preset_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0] cmd_strb = '0;
    logic [2:0] cmd_prot = '0;
    logic rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic [SN-1:0] psel, pready, pslverr;
    logic penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0] pstrb;
    logic [2:0] pprot;
    logic [32*SN-1:0] prdata;

    int errors = 0, checks = 0;

    apb_master_ctrl #(.SLAVE_NUM(SN), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // slave models: selected slave answers after slave_wait ACCESS cycles
    int          slave_wait [4];
    logic        slave_err  [4];
    logic [31:0] slave_data [4];
    logic [3:0]  noise_rdy = '0, noise_err = '0;
    int          acc_cnt;

    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) acc_cnt <= 0;
        else if (penable && ((pready & psel) == '0)) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always_comb begin
        pready  = '0;
        pslverr = '0;
        prdata  = '0;
        for (int i = 0; i < SN; i++) begin
            pready[i]  = psel[i] ? (penable && acc_cnt >= slave_wait[i]) : noise_rdy[i];
            pslverr[i] = psel[i] ? slave_err[i] : noise_err[i];
            prdata[32*i +: 32] = slave_data[i];
        end
    end

    // observations of the last transaction
    int          ob_lat, ob_nsetup, ob_nacc;
    logic        ob_stable, ob_busy_ok, ob_hold_ok, ob_ready_after;
    logic [3:0]  ob_psel, ob_psel_setup, ob_pstrb, ob_pstrb_acc;
    logic [31:0] ob_paddr, ob_pwdata, ob_rdata;
    logic        ob_pwrite;
    logic [2:0]  ob_pprot;
    logic [1:0]  ob_err;

    // reference expectations
    int          ex_lat, ex_nacc;
    logic [3:0]  ex_psel, ex_pstrb;
    logic [31:0] ex_pwdata, ex_rdata;
    logic [1:0]  ex_err;

    task automatic model_txn(input logic [31:0] a, input logic w,
                             input logic [31:0] wd, input logic [3:0] st);
        int idx;
        if (a >= 32'h4000) begin
            ex_lat = 1; ex_nacc = 0; ex_psel = 4'h0; ex_rdata = 0; ex_err = 2'b11;
        end else begin
            idx = int'(a / 32'h1000);
            ex_psel = 4'(1 << idx);
            if (slave_wait[idx] >= TMO) begin
                ex_nacc = TMO; ex_lat = 2 + TMO; ex_rdata = 0; ex_err = 2'b10;
            end else begin
                ex_nacc  = slave_wait[idx] + 1;
                ex_lat   = 2 + ex_nacc;
                ex_rdata = w ? 32'h0 : slave_data[idx];
                ex_err   = slave_err[idx] ? 2'b10 : 2'b00;
            end
        end
        ex_pwdata = w ? wd : 32'h0;
        ex_pstrb  = w ? st : 4'h0;
    endtask

    task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] pr, input int hold);
        int guard = 0;
        while (!cmd_ready && guard < 50) begin @(negedge pclk); guard++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = wd;
        cmd_strb = st; cmd_prot = pr;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
        cmd_write = 1'($urandom); cmd_strb = 4'($urandom);
        ob_lat = -1; ob_nsetup = 0; ob_nacc = 0; ob_stable = 1'b1; ob_busy_ok = 1'b1;
        ob_psel = '0; ob_pstrb_acc = '0; ob_psel_setup = '0;
        for (int c = 1; c <= 100; c++) begin
            if (cmd_ready !== 1'b0) ob_busy_ok = 1'b0;
            if (psel != '0 && !penable) begin
                ob_nsetup++;
                ob_psel_setup = psel; ob_paddr = paddr; ob_pwrite = pwrite;
                ob_pwdata = pwdata; ob_pstrb = pstrb; ob_pprot = pprot;
            end
            if (penable) begin
                ob_nacc++;
                ob_pstrb_acc |= pstrb;
                if (psel !== ob_psel_setup || paddr !== ob_paddr || pwdata !== ob_pwdata ||
                    pstrb !== ob_pstrb || pwrite !== ob_pwrite || pprot !== ob_pprot)
                    ob_stable = 1'b0;
            end
            ob_psel |= psel;
            if (rsp_valid) begin
                ob_lat = c; ob_rdata = rsp_rdata; ob_err = rsp_err;
                break;
            end
            @(negedge pclk);
        end
        if (ob_lat < 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: no rsp_valid within 100 cycles, addr=%h", a);
            ob_rdata = 'x; ob_err = 'x;
        end
        ob_hold_ok = 1'b1;
        repeat (hold) begin
            @(negedge pclk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== ob_rdata || rsp_err !== ob_err ||
                cmd_ready !== 1'b0 || psel !== '0)
                ob_hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        ob_ready_after = (cmd_ready === 1'b1) && (rsp_valid === 1'b0);
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        repeat (3) @(negedge pclk);
        checks++; if ({psel, penable, pwrite, rsp_valid} !== '0) begin errors++;
            $display("FAIL reset_ctrl: psel=%b penable=%b pwrite=%b rsp_valid=%b required 0", psel, penable, pwrite, rsp_valid); end
        checks++; if ({paddr, pwdata, pstrb, pprot} !== '0) begin errors++;
            $display("FAIL reset_bus: paddr=%h pwdata=%h pstrb=%h pprot=%h required 0", paddr, pwdata, pstrb, pprot); end
        checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 2'b00) begin errors++;
            $display("FAIL reset_rsp: rdata=%h err=%b required 0/00", rsp_rdata, rsp_err); end
        preset_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++;
            $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
        @(negedge pclk);
    endtask

    task automatic test_read_zero_wait();
        slave_wait[1] = 0; slave_err[1] = 0; slave_data[1] = 32'hDEAD_BEEF;
        run_txn(32'h0000_1004, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b010, 0);
        checks++; if (ob_nsetup !== 1 || ob_nacc !== 1) begin errors++;
            $display("FAIL rd_phases: setup=%0d access=%0d required 1/1", ob_nsetup, ob_nacc); end
        checks++; if (ob_psel !== 4'b0010) begin errors++;
            $display("FAIL rd_psel: got %b required 0010", ob_psel); end
        checks++; if (ob_lat !== 3) begin errors++;
            $display("FAIL rd_latency: got %0d required 3", ob_lat); end
        checks++; if (ob_rdata !== 32'hDEAD_BEEF || ob_err !== 2'b00) begin errors++;
            $display("FAIL rd_rsp: rdata=%h err=%b required deadbeef/00", ob_rdata, ob_err); end
        checks++; if (ob_pstrb !== 4'h0 || ob_pstrb_acc !== 4'h0 || ob_pwdata !== 32'h0) begin errors++;
            $display("FAIL rd_pstrb: pstrb=%h/%h pwdata=%h required 0", ob_pstrb, ob_pstrb_acc, ob_pwdata); end
        checks++; if (ob_paddr !== 32'h0000_1004 || ob_pprot !== 3'b010 || ob_pwrite !== 1'b0) begin errors++;
            $display("FAIL rd_addr: paddr=%h pprot=%b pwrite=%b required 00001004/010/0", ob_paddr, ob_pprot, ob_pwrite); end
        checks++; if (!ob_ready_after) begin errors++;
            $display("FAIL rd_ready_after: got 0 required 1"); end
    endtask

    task automatic test_write_wait();
        slave_wait[0] = 3; slave_err[0] = 0; slave_data[0] = 32'h7777_7777;
        run_txn(32'h0000_0008, 1'b1, 32'h1234_5678, 4'hF, 3'b000, 0);
        checks++; if (ob_nacc !== 4 || !ob_stable) begin errors++;
            $display("FAIL wr_wait: access=%0d stable=%b required 4/1", ob_nacc, ob_stable); end
        checks++; if (ob_pwdata !== 32'h1234_5678 || ob_pstrb !== 4'hF || ob_pwrite !== 1'b1) begin errors++;
            $display("FAIL wr_bus: pwdata=%h pstrb=%h pwrite=%b required 12345678/f/1", ob_pwdata, ob_pstrb, ob_pwrite); end
        checks++; if (ob_rdata !== 32'h0 || ob_err !== 2'b00 || ob_lat !== 6) begin errors++;
            $display("FAIL wr_rsp: rdata=%h err=%b lat=%0d required 0/00/6", ob_rdata, ob_err, ob_lat); end
    endtask

    task automatic test_decode_miss();
        run_txn(32'h0000_5000, 1'b0, 32'h0, 4'h0, 3'b000, 0);
        checks++; if (ob_psel !== 4'h0 || ob_nacc !== 0) begin errors++;
            $display("FAIL miss_psel: psel=%b access=%0d required 0/0", ob_psel, ob_nacc); end
        checks++; if (ob_lat !== 1 || ob_err !== 2'b11 || ob_rdata !== 32'h0) begin errors++;
            $display("FAIL miss_rsp: lat=%0d err=%b rdata=%h required 1/11/0", ob_lat, ob_err, ob_rdata); end
    endtask

    task automatic test_slverr();
        slave_wait[2] = 0; slave_err[2] = 1; slave_data[2] = 32'hA5A5_A5A5;
        run_txn(32'h0000_2000, 1'b0, 32'h0, 4'h0, 3'b001, 0);
        checks++; if (ob_err !== 2'b10 || ob_rdata !== 32'hA5A5_A5A5) begin errors++;
            $display("FAIL slverr: err=%b rdata=%h required 10/a5a5a5a5", ob_err, ob_rdata); end
        slave_err[2] = 0;
    endtask

    task automatic test_timeout();
        slave_wait[3] = 1000; slave_err[3] = 0; slave_data[3] = 32'hCAFE_F00D;
        run_txn(32'h0000_3010, 1'b0, 32'h0, 4'h0, 3'b000, 0);
        checks++; if (ob_nacc !== TMO || ob_lat !== TMO + 2) begin errors++;
            $display("FAIL tmo_len: access=%0d lat=%0d required %0d/%0d", ob_nacc, ob_lat, TMO, TMO + 2); end
        checks++; if (ob_err !== 2'b10 || ob_rdata !== 32'h0 || !ob_ready_after) begin errors++;
            $display("FAIL tmo_rsp: err=%b rdata=%h ready_after=%b required 10/0/1", ob_err, ob_rdata, ob_ready_after); end
        slave_wait[3] = 0;
        run_txn(32'h0000_3FFC, 1'b0, 32'h0, 4'h0, 3'b000, 0);
        checks++; if (ob_lat !== 3 || ob_err !== 2'b00 || ob_rdata !== 32'hCAFE_F00D) begin errors++;
            $display("FAIL tmo_next: lat=%0d err=%b rdata=%h required 3/00/cafef00d", ob_lat, ob_err, ob_rdata); end
    endtask

    task automatic test_backpressure();
        slave_wait[1] = 1; slave_data[1] = 32'h0BAD_F00D;
        run_txn(32'h0000_1FFC, 1'b0, 32'h0, 4'h0, 3'b000, 5);
        checks++; if (!ob_hold_ok || !ob_busy_ok) begin errors++;
            $display("FAIL backpressure: hold_ok=%b busy_ok=%b required 1/1", ob_hold_ok, ob_busy_ok); end
        checks++; if (ob_rdata !== 32'h0BAD_F00D || !ob_ready_after) begin errors++;
            $display("FAIL bp_rsp: rdata=%h ready_after=%b required 0badf00d/1", ob_rdata, ob_ready_after); end
    endtask

    task automatic test_reset_mid();
        slave_wait[0] = 10;
        cmd_valid = 1'b1; cmd_addr = 32'h0000_0100; cmd_write = 1'b0;
        @(posedge pclk); @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        checks++; if (penable !== 1'b1) begin errors++;
            $display("FAIL rstmid_access: penable=%b required 1", penable); end
        preset_n = 1'b0;
        #1;
        checks++; if (psel !== '0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin errors++;
            $display("FAIL rstmid_drop: psel=%b penable=%b rsp_valid=%b required 0", psel, penable, rsp_valid); end
        @(negedge pclk);
        preset_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++;
            $display("FAIL rstmid_ready: cmd_ready=%b required 1", cmd_ready); end
        repeat (3) @(negedge pclk);
        checks++; if (rsp_valid !== 1'b0 || psel !== '0) begin errors++;
            $display("FAIL rstmid_discard: rsp_valid=%b psel=%b required 0", rsp_valid, psel); end
    endtask

    task automatic test_random();
        logic [31:0] a, wd;
        logic w;
        logic [3:0] st;
        logic [2:0] pr;
        int r;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                slave_wait[i] = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
                slave_err[i]  = 1'($urandom);
                slave_data[i] = $urandom;
            end
            noise_rdy = 4'($urandom); noise_err = 4'($urandom);
            r = int'($urandom_range(0, 5));
            a  = (r < 4) ? (32'(r) * 32'h1000 + 32'($urandom_range(0, 4095)))
                         : ($urandom | 32'h0001_0000);
            w  = 1'($urandom); wd = $urandom; st = 4'($urandom); pr = 3'($urandom);
            model_txn(a, w, wd, st);
            run_txn(a, w, wd, st, pr, int'($urandom_range(0, 2)));
            checks++; if (ob_lat !== ex_lat || ob_nacc !== ex_nacc) begin errors++;
                $display("FAIL rnd_timing[%0d]: lat=%0d acc=%0d required %0d/%0d addr=%h", n, ob_lat, ob_nacc, ex_lat, ex_nacc, a); end
            checks++; if (ob_psel !== ex_psel) begin errors++;
                $display("FAIL rnd_psel[%0d]: got %b required %b addr=%h", n, ob_psel, ex_psel, a); end
            checks++; if (ob_rdata !== ex_rdata || ob_err !== ex_err) begin errors++;
                $display("FAIL rnd_rsp[%0d]: rdata=%h err=%b required %h/%b", n, ob_rdata, ob_err, ex_rdata, ex_err); end
            if (ex_psel != 4'h0) begin
                checks++; if (ob_paddr !== a || ob_pwrite !== w || ob_pprot !== pr ||
                              ob_pwdata !== ex_pwdata || ob_pstrb !== ex_pstrb || !ob_stable) begin errors++;
                    $display("FAIL rnd_bus[%0d]: paddr=%h pwrite=%b pprot=%b pwdata=%h pstrb=%h stable=%b required %h/%b/%b/%h/%h/1",
                             n, ob_paddr, ob_pwrite, ob_pprot, ob_pwdata, ob_pstrb, ob_stable, a, w, pr, ex_pwdata, ex_pstrb); end
            end
            checks++; if (!ob_ready_after || !ob_hold_ok || !ob_busy_ok) begin errors++;
                $display("FAIL rnd_hs[%0d]: ready_after=%b hold_ok=%b busy_ok=%b required 1/1/1", n, ob_ready_after, ob_hold_ok, ob_busy_ok); end
        end
        noise_rdy = '0; noise_err = '0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            slave_wait[i] = 0; slave_err[i] = 1'b0; slave_data[i] = '0;
        end
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_decode_miss();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
